// File: rtl/rt_pkg.sv
// Shared definitions for the reaction timer: FSM states, LFSR seed/taps and
// BCD constants used by the core and its counter.
package rt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_TIMING = 3'd2,
    ST_DONE   = 3'd3,
    ST_FAULT  = 3'd4
  } state_t;

  localparam logic [15:0] LFSR_SEED   = 16'hACE1;
  // Taps at bits 15,13,12,10 implement x^16+x^14+x^13+x^11+1.
  localparam logic [15:0] LFSR_TAPS   = 16'hB400;
  localparam logic [3:0]  FAULT_DIGIT = 4'hF;
  localparam logic [15:0] BCD_MAX     = 16'h9999;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD up-counter with synchronous clear; holds at 9999 instead of
// wrapping so a slow user sees the maximum rather than a small number.
module bcd_counter4
  import rt_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] dig3,
  output logic [3:0] dig2,
  output logic [3:0] dig1,
  output logic [3:0] dig0
);

  logic [3:0][3:0] dig_q, dig_d;
  logic            carry;

  // NOTE: every variable assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    dig_d = dig_q;
    carry = 1'b1;
    if (clr) begin
      dig_d = '0;
    end else if (inc && (dig_q != BCD_MAX)) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (dig_q[i] == 4'd9) begin
            dig_d[i] = 4'd0;
          end else begin
            dig_d[i] = dig_q[i] + 4'd1;
            carry    = 1'b0;
          end
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dig_q <= '0;
    else        dig_q <= dig_d;
  end

  assign dig3 = dig_q[3];
  assign dig2 = dig_q[2];
  assign dig1 = dig_q[1];
  assign dig0 = dig_q[0];

endmodule

// File: rtl/reaction_timer_core.sv
// Reaction timer: random wait, stimulus light, then ms count until react.
// Digit outputs feed external seven-segment decoders.
module reaction_timer_core
  import rt_pkg::*;
#(
  parameter int TICK_DIV     = 50000,
  parameter int DELAY_MIN_MS = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       react,
  output logic [3:0] dig3,
  output logic [3:0] dig2,
  output logic [3:0] dig1,
  output logic [3:0] dig0,
  output logic       stim_led,
  output logic       busy,
  output logic       early
);

  localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int WAIT_W = $clog2(DELAY_MIN_MS + 1024);

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [15:0]         lfsr_q;
  logic                tick, cnt_clr, cnt_inc;
  logic [3:0]          cnt3, cnt2, cnt1, cnt0;

  assign tick = (div_q == DIV_W'(TICK_DIV - 1));

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_FAULT: begin
        if (start) begin
          state_d = ST_WAIT;
          cnt_clr = 1'b1;
          wait_d  = WAIT_W'(DELAY_MIN_MS) + WAIT_W'(lfsr_q[9:0]);
        end
      end
      ST_WAIT: begin
        // A premature react beats a coincident final tick.
        if (react) begin
          state_d = ST_FAULT;
        end else if (tick) begin
          if (wait_q <= WAIT_W'(1)) begin
            wait_d  = '0;
            state_d = ST_TIMING;
          end else begin
            wait_d = wait_q - WAIT_W'(1);
          end
        end
      end
      ST_TIMING: begin
        if (react)     state_d = ST_DONE;
        else if (tick) cnt_inc = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Divider restarts on every state change so each phase begins on a full ms.
  assign div_d = (tick || (state_d != state_q)) ? '0 : div_q + DIV_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      wait_q  <= '0;
      lfsr_q  <= LFSR_SEED;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      wait_q  <= wait_d;
      lfsr_q  <= lfsr_next(lfsr_q);
    end
  end

  bcd_counter4 u_count (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .dig3  (cnt3),
    .dig2  (cnt2),
    .dig1  (cnt1),
    .dig0  (cnt0)
  );

  assign stim_led = (state_q == ST_TIMING);
  assign busy     = (state_q == ST_WAIT) || (state_q == ST_TIMING);
  assign early    = (state_q == ST_FAULT);

  assign dig3 = early ? FAULT_DIGIT : cnt3;
  assign dig2 = early ? FAULT_DIGIT : cnt2;
  assign dig1 = early ? FAULT_DIGIT : cnt1;
  assign dig0 = early ? FAULT_DIGIT : cnt0;

endmodule

// File: tb/tb_reaction_timer_core.sv
// Self-checking bench for reaction_timer_core with TICK_DIV=4, DELAY_MIN_MS=2.
// Expected digits are queued when react is driven and compared once DONE shows.
module tb_reaction_timer_core;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       react = 1'b0;
  logic [3:0] dig3, dig2, dig1, dig0;
  logic       stim_led, busy, early;
  logic [15:0] digs;
  logic [15:0] m_lfsr;
  logic [15:0] exp_q[$];
  int          pass_cnt = 0;
  int          chk_cnt  = 0;

  assign digs = {dig3, dig2, dig1, dig0};

  reaction_timer_core #(.TICK_DIV(4), .DELAY_MIN_MS(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .react(react),
    .dig3(dig3), .dig2(dig2), .dig1(dig1), .dig0(dig0),
    .stim_led(stim_led), .busy(busy), .early(early)
  );

  always #5 clk = ~clk;

  // Reference LFSR: x^16+x^14+x^13+x^11+1, seed ACE1, one step per clock.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  function automatic logic [15:0] bcd_of(input int k);
    int v;
    v = (k > 9999) ? 9999 : k;
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_react();
    react = 1'b1;
    @(negedge clk);
    react = 1'b0;
  endtask

  // Starts a trial from a negedge; returns at the negedge just after TIMING began.
  task automatic enter_timing(input string nm);
    int n;
    n = 2 + int'(m_lfsr[9:0]);
    pulse_start();
    chk_cnt++;
    if (busy !== 1'b1 || stim_led !== 1'b0 || digs !== 16'h0000)
      $display("FAIL %s_wait_entry: busy=%b stim=%b digs=%h, want busy=1 stim=0 digs=0000", nm, busy, stim_led, digs);
    else pass_cnt++;
    repeat (4 * n - 1) @(negedge clk);
    chk_cnt++;
    if (stim_led !== 1'b0)
      $display("FAIL %s_stim_early: stim=%b one cycle before %0d cycles, want 0", nm, stim_led, 4 * n);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (stim_led !== 1'b1 || busy !== 1'b1 || digs !== 16'h0000)
      $display("FAIL %s_stim_on: stim=%b busy=%b digs=%h after %0d cycles, want 1 1 0000", nm, stim_led, busy, digs, 4 * n);
    else pass_cnt++;
  endtask

  task automatic finish_react(input int ticks, input string nm);
    logic [15:0] exp;
    exp_q.push_back(bcd_of(ticks));
    pulse_react();
    for (int i = 0; i < 4 && busy !== 1'b0; i++) @(negedge clk);
    exp = exp_q.pop_front();
    chk_cnt++;
    if (busy !== 1'b0)
      $display("FAIL %s_done_timeout: busy=%b, want 0 within 4 cycles", nm, busy);
    else pass_cnt++;
    chk_cnt++;
    if (digs !== exp || stim_led !== 1'b0 || early !== 1'b0)
      $display("FAIL %s_done: digs=%h stim=%b early=%b, want digs=%h stim=0 early=0", nm, digs, stim_led, early, exp);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    #1;
    chk_cnt++;
    if (digs !== 16'h0000 || stim_led !== 1'b0 || busy !== 1'b0 || early !== 1'b0)
      $display("FAIL reset_state: digs=%h stim=%b busy=%b early=%b, want all 0", digs, stim_led, busy, early);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_timing();
    enter_timing("t37");
    repeat (148) @(negedge clk);
    finish_react(37, "t37");
    repeat (20) @(negedge clk);
    chk_cnt++;
    if (digs !== 16'h0037 || busy !== 1'b0)
      $display("FAIL t37_hold: digs=%h busy=%b, want 0037 0", digs, busy);
    else pass_cnt++;
  endtask

  task automatic test_fault();
    pulse_start();
    repeat (2) @(negedge clk);
    pulse_react();
    chk_cnt++;
    if (early !== 1'b1 || digs !== 16'hFFFF || busy !== 1'b0 || stim_led !== 1'b0)
      $display("FAIL fault_entry: early=%b digs=%h busy=%b stim=%b, want 1 FFFF 0 0", early, digs, busy, stim_led);
    else pass_cnt++;
    pulse_react();
    chk_cnt++;
    if (early !== 1'b1 || digs !== 16'hFFFF)
      $display("FAIL fault_react_ignored: early=%b digs=%h, want 1 FFFF", early, digs);
    else pass_cnt++;
    pulse_start();
    chk_cnt++;
    if (early !== 1'b0 || digs !== 16'h0000 || busy !== 1'b1)
      $display("FAIL fault_restart: early=%b digs=%h busy=%b, want 0 0000 1", early, digs, busy);
    else pass_cnt++;
    pulse_react();
  endtask

  task automatic test_coincident();
    enter_timing("c99");
    repeat (399) @(negedge clk);
    finish_react(99, "c99");
  endtask

  task automatic test_saturate();
    enter_timing("sat");
    repeat (40040) @(negedge clk);
    chk_cnt++;
    if (digs !== 16'h9999 || stim_led !== 1'b1 || busy !== 1'b1)
      $display("FAIL sat_hold: digs=%h stim=%b busy=%b, want 9999 1 1", digs, stim_led, busy);
    else pass_cnt++;
    finish_react(10010, "sat");
  endtask

  task automatic test_reset_mid();
    enter_timing("rst");
    repeat (20) @(negedge clk);
    pulse_start();
    chk_cnt++;
    if (digs !== 16'h0005 || stim_led !== 1'b1 || busy !== 1'b1)
      $display("FAIL rst_start_ignored: digs=%h stim=%b busy=%b, want 0005 1 1", digs, stim_led, busy);
    else pass_cnt++;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_cnt++;
    if (digs !== 16'h0000 || stim_led !== 1'b0 || busy !== 1'b0 || early !== 1'b0)
      $display("FAIL rst_async: digs=%h stim=%b busy=%b early=%b, want all 0", digs, stim_led, busy, early);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_react();
    repeat (40) @(negedge clk);
    chk_cnt++;
    if (digs !== 16'h0000 || stim_led !== 1'b0 || busy !== 1'b0 || early !== 1'b0)
      $display("FAIL rst_idle_react: digs=%h stim=%b busy=%b early=%b, want all 0", digs, stim_led, busy, early);
    else pass_cnt++;
    pulse_start();
    chk_cnt++;
    if (busy !== 1'b1 || digs !== 16'h0000)
      $display("FAIL rst_new_start: busy=%b digs=%h, want 1 0000", busy, digs);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_timing();
    test_fault();
    test_coincident();
    test_saturate();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/reaction_timer_core.md
REACTION_TIMER_CORE -- requirements
Module: reaction_timer_core

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000, meaning clock cycles per 1 ms tick (50 MHz board clock).
REQ-002 SHALL have parameter DELAY_MIN_MS, default 1000, meaning the minimum random wait in ms before the stimulus.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1 bit: single-cycle pulse that arms a trial; it is already debounced and synchronised.
REQ-006 SHALL have port react, input, 1 bit: single-cycle pulse for the user response; it is already debounced and synchronised.
REQ-007 SHALL have ports dig3, dig2, dig1, dig0, output, 4 bits each: BCD thousands/hundreds/tens/units of ms, each feeding one seven-segment decoder.
REQ-008 SHALL have port stim_led, output, 1 bit: stimulus light, high only in TIMING.
REQ-009 SHALL have port busy, output, 1 bit: high in WAIT or TIMING.
REQ-010 SHALL have port early, output, 1 bit: high in FAULT.

Function
REQ-011 SHALL implement states IDLE, WAIT, TIMING, DONE, FAULT.
REQ-012 SHALL produce a 1 ms tick as a one-cycle strobe every TICK_DIV cycles; the divider clears on every state change.
REQ-013 SHALL run a free-running 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, seed 16'hACE1, never all-zero.
REQ-014 SHALL, on start in IDLE, DONE or FAULT, clear all digits to 0, load the wait counter with DELAY_MIN_MS + lfsr[9:0] (range 1000..2023 ms), and enter WAIT on the next edge.
REQ-015 SHALL, in WAIT, decrement the wait counter once per tick and enter TIMING on the tick that takes it to 0.
REQ-016 SHALL, on react in WAIT, enter FAULT and set all four digits to 4'hF.
REQ-017 SHALL, in TIMING, increment the 4-digit BCD count by 1 per tick, with each digit wrapping 9->0 and carrying into the next digit.
REQ-018 SHALL saturate the count at 9999: when at 9999, further ticks leave the digits unchanged and the state stays TIMING.
REQ-019 SHALL, on react in TIMING, enter DONE and freeze the digits; if react and tick occur in the same cycle, react wins and the count is not incremented.
REQ-020 SHALL ignore start in WAIT and TIMING, and ignore react in IDLE, DONE and FAULT.
REQ-021 SHALL, if start and react occur in the same cycle, apply only the rule for the current state.
REQ-022 SHALL drive stim_led, busy and early directly from state registers, with no combinational path from inputs.
REQ-023 SHALL keep each digit in the range 0..9, except for 4'hF in FAULT.

Reset
REQ-024 SHALL, while rst_n is low, force state IDLE, digits 0, stim_led 0, busy 0, early 0, divider 0, wait counter 0, and LFSR 16'hACE1.
REQ-025 SHALL, when reset is asserted mid-trial (WAIT or TIMING), abort the trial with no residual count, and SHALL require a new start after reset.

Structure
REQ-026 SHALL place the state enum, the LFSR seed/taps and the 4'hF fault code in a shared package, rt_pkg.
REQ-027 SHALL implement the 4-digit BCD incrementer with saturation as a sub-module, bcd_counter4 (inputs clr, inc; outputs four digits).
REQ-028 SHALL leave the seven-segment decoding outside this block; the four digit outputs connect directly to four decoder instances.

Verification (TICK_DIV=4, DELAY_MIN_MS=2)
REQ-029 SHALL verify: reset, then start -> busy=1 next cycle, stim_led=1 after (2+lfsr[9:0])*4 cycles, digits 0000.
REQ-030 SHALL verify: react after 37 ticks in TIMING -> DONE, digits 0,0,3,7, stim_led=0, busy=0, digits then hold.
REQ-031 SHALL verify: react during WAIT -> early=1, digits F,F,F,F; then start -> early=0, digits 0000, WAIT.
REQ-032 SHALL verify: no react for 10010 ticks -> digits saturate at 9,9,9,9 while TIMING holds; react -> DONE showing 9999.
REQ-033 SHALL verify: react coincident with tick at count 0099 -> digits stay 0,0,9,9 (no carry to 0100).
REQ-034 SHALL verify: rst_n low mid-TIMING -> all outputs 0 asynchronously; start ignored during TIMING; react ignored in IDLE.
